mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- MEM stage of the 5-stage RISC-V pipeline, between the EX/MEM register and the memory/writeback interface.
- Accepts one instruction at a time from execute.
- For loads and stores, runs a request/grant/response transaction on the data-memory port; for all other instructions, passes results straight through.
- Registers results (LMD, ALU result, npc, condpc, control) into a MEM/WB output register, with valid/ready handshakes on both sides.

Parameters:
- DATA_WIDTH, 32, datapath and address width; fixed at 32 for byte-lane logic. Taken from riscv_pkg.
- REG_ADDR_W, 5, destination register index width.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  execute presents an instruction
- ex_ready  out  1  stage can accept an instruction
- ex_alu_result  in  32  ALU output / memory address
- ex_reg_b  in  32  store data (REG_B)
- ex_rd  in  5  destination register
- ex_reg_write  in  1  instruction writes rd
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_funct3  in  3  access size/sign
- ex_cond  in  1  branch condition
- ex_npc  in  32  next sequential pc
- ex_condpc  in  32  branch target
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned address
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read data
- wb_valid  out  1  output register holds valid result
- wb_ready  in  1  writeback consumes result
- wb_lmd  out  32  aligned, extended load data
- wb_alu_result  out  32  registered ALU result
- wb_rd  out  5  destination register
- wb_reg_write  out  1  write enable to register file
- wb_mem_to_reg  out  1  select LMD
- wb_cond  out  1  registered cond
- wb_npc  out  32  registered npc
- wb_condpc  out  32  registered condpc
- wb_misalign  out  1  misaligned access flag

Behaviour:
- Reset: rst_n low asynchronously forces FSM to IDLE and every output to 0, including wb_valid, dmem_req and wb_misalign.
- Reset mid-transaction: the transaction is abandoned; dmem_rvalid or dmem_gnt arriving in IDLE is ignored.
- ex_ready = (state==IDLE) && (!wb_valid || wb_ready), purely combinational. An accept is ex_valid && ex_ready at a clock edge.
- FSM states: IDLE, REQ, RESP.
- Non-memory instruction (!ex_mem_read && !ex_mem_write):
  - Output register loaded on the accept edge; latency 1.
  - wb_mem_to_reg = 0; wb_lmd = 0.
- Load or store accepted: latch instruction fields; go to REQ.
- REQ:
  - dmem_req = 1; dmem_addr = {addr[31:2], 2'b00}; dmem_we, dmem_be, dmem_wdata are held stable until dmem_gnt.
  - On gnt with a store: load the output register and return to IDLE.
  - On gnt with a load: go to RESP.
- RESP:
  - dmem_req = 0.
  - On dmem_rvalid: format rdata into wb_lmd, load the output register with wb_mem_to_reg = 1, return to IDLE.
- Load formatting (byte lane = addr[1:0]; half lane = addr[1]):
  - LB 000: sign-extend byte.
  - LH 001: sign-extend half.
  - LW 010: full word.
  - LBU 100: zero-extend byte.
  - LHU 101: zero-extend half.
  - Other funct3 values: treat as LW.
- Store formatting:
  - SB: wdata = {4{b}}, be = 4'b0001 << addr[1:0].
  - SH: wdata = {2{h}}, be = 4'b0011 << {addr[1], 1'b0}.
  - SW: be = 4'b1111.
- Output register:
  - Holds its value while wb_valid && !wb_ready.
  - wb_valid clears when wb_ready is high and no new result is loaded on that edge.
  - Load and consume on the same edge is allowed and gives back-to-back throughput for non-memory instructions.
- ex_mem_read and ex_mem_write both set: treated as a load.

Optional Feature:
MEM_MISALIGN_CHECK_EN
- Defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, is not issued to memory.
  - The output register is loaded on the accept edge with wb_misalign = 1 and wb_reg_write = 0.
- Undefined:
  - wb_misalign is tied 0.
  - Low address bits beyond the lane select are ignored; the access proceeds with the computed lane.

Decomposition:
- riscv_pkg holds:
  - DATA_WIDTH.
  - funct3 load/store constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW).
  - mem_state_e enum {IDLE, REQ, RESP}.
- Sub-module mem_load_align: combinational funct3 + addr[1:0] + rdata -> extended 32-bit LMD. Reused by later cache work.

Test Plan:
- ALU op, alu_result=0x0000_1234, rd=5, wb_ready=1 -> wb_valid next cycle, wb_alu_result=0x1234, wb_mem_to_reg=0, no dmem_req.
- LB at addr 0x103, gnt after 2 cycles, rdata=0x80FF_FFFF -> dmem_addr=0x100, be=0; wb_lmd=0xFFFF_FF80 one cycle after rvalid.
- SH at addr 0x202, reg_b=0x0000_BEEF -> dmem_wdata=0xBEEF_BEEF, be=4'b1100, dmem_we=1; wb_valid after gnt; ex_ready low throughout.
- Load completes with wb_ready=0 for 3 cycles -> wb_lmd/wb_valid held stable, ex_ready=0; accepts the next instruction on the cycle wb_ready rises.
- rst_n pulsed low in RESP, then stray rvalid -> all outputs 0, state IDLE, rvalid ignored, ex_ready=1 after release.
- With MEM_MISALIGN_CHECK_EN: LW at 0x101 -> no dmem_req, wb_misalign=1, wb_reg_write=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V constants for the MEM stage: datapath width, load/store funct3
// codes, MEM FSM states and access-size helpers.
package riscv_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  // Unlisted funct3 codes fall back to a full-word access.
  function automatic mem_size_e access_size(input logic [2:0] f3, input logic is_load);
    mem_size_e sz;
    sz = SZ_WORD;
    if (is_load) begin
      if (f3 == F3_LB || f3 == F3_LBU)      sz = SZ_BYTE;
      else if (f3 == F3_LH || f3 == F3_LHU) sz = SZ_HALF;
      else                                  sz = SZ_WORD;
    end else begin
      case (f3)
        F3_SB:   sz = SZ_BYTE;
        F3_SH:   sz = SZ_HALF;
        F3_SW:   sz = SZ_WORD;
        default: sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

  function automatic logic is_misaligned(input mem_size_e sz, input logic [1:0] lo);
    logic mis;
    case (sz)
      SZ_HALF: mis = lo[0];
      SZ_WORD: mis = (lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/grant/response bus; master is the MEM stage, slave is memory.
interface mem_access_stage_if;

  logic                                dmem_req;
  logic                                dmem_we;
  logic [riscv_pkg::DATA_WIDTH-1:0]    dmem_addr;
  logic [riscv_pkg::DATA_WIDTH-1:0]    dmem_wdata;
  logic [riscv_pkg::DATA_WIDTH/8-1:0]  dmem_be;
  logic                                dmem_gnt;
  logic                                dmem_rvalid;
  logic [riscv_pkg::DATA_WIDTH-1:0]    dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );

endinterface

// File: rtl/mem_load_align.sv
// Load data formatter: selects the byte/half lane from a 32-bit read word and
// sign- or zero-extends it according to funct3.
module mem_load_align
  import riscv_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_lmd
);

  logic [31:0] w_byte_sh;
  logic [31:0] w_half_sh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte_sh = i_rdata >> {i_addr_lo, 3'b000};
    w_half_sh = i_rdata >> {i_addr_lo[1], 4'b0000};
    w_byte    = w_byte_sh[7:0];
    w_half    = w_half_sh[15:0];
    case (i_funct3)
      F3_LB:   o_lmd = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_lmd = {{16{w_half[15]}}, w_half};
      F3_LW:   o_lmd = i_rdata;
      F3_LBU:  o_lmd = {24'h0, w_byte};
      F3_LHU:  o_lmd = {16'h0, w_half};
      default: o_lmd = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: runs load/store transactions on the data-memory bus, passes other
// instructions through, and registers results into the MEM/WB output register.
// Optional misaligned-access trapping is enabled with `define MEM_MISALIGN_CHECK_EN.
module mem_access_stage #(
  parameter int unsigned DATA_WIDTH = riscv_pkg::DATA_WIDTH,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [DATA_WIDTH-1:0] ex_alu_result,
  input  logic [DATA_WIDTH-1:0] ex_reg_b,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic [2:0]            ex_funct3,
  input  logic                  ex_cond,
  input  logic [DATA_WIDTH-1:0] ex_npc,
  input  logic [DATA_WIDTH-1:0] ex_condpc,

  mem_access_stage_if.master    dmem,

  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [DATA_WIDTH-1:0] wb_lmd,
  output logic [DATA_WIDTH-1:0] wb_alu_result,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg,
  output logic                  wb_cond,
  output logic [DATA_WIDTH-1:0] wb_npc,
  output logic [DATA_WIDTH-1:0] wb_condpc,
  output logic                  wb_misalign
);

  import riscv_pkg::*;

  mem_state_e r_state, w_state_nxt;

  logic      w_ex_ready;
  logic      w_accept;
  logic      w_is_mem;
  logic      w_misalign;
  logic      w_latch;
  logic      w_out_load;
  logic      w_in_req;
  mem_size_e w_size;

  logic [DATA_WIDTH-1:0] w_st_wdata;
  logic [3:0]            w_st_be;
  logic [DATA_WIDTH-1:0] w_lmd;

  // Fields of the in-flight memory instruction
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [3:0]            r_be;
  logic [2:0]            r_funct3;
  logic                  r_is_load;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_reg_write;
  logic                  r_cond;
  logic [DATA_WIDTH-1:0] r_npc;
  logic [DATA_WIDTH-1:0] r_condpc;

  // MEM/WB output register
  logic                  r_wb_valid;
  logic [DATA_WIDTH-1:0] r_wb_lmd;
  logic [DATA_WIDTH-1:0] r_wb_alu;
  logic [REG_ADDR_W-1:0] r_wb_rd;
  logic                  r_wb_rw;
  logic                  r_wb_m2r;
  logic                  r_wb_cond;
  logic [DATA_WIDTH-1:0] r_wb_npc;
  logic [DATA_WIDTH-1:0] r_wb_condpc;

  logic [DATA_WIDTH-1:0] w_nx_lmd;
  logic [DATA_WIDTH-1:0] w_nx_alu;
  logic [REG_ADDR_W-1:0] w_nx_rd;
  logic                  w_nx_rw;
  logic                  w_nx_m2r;
  logic                  w_nx_cond;
  logic [DATA_WIDTH-1:0] w_nx_npc;
  logic [DATA_WIDTH-1:0] w_nx_condpc;

  assign w_ex_ready = (r_state == IDLE) && (!r_wb_valid || wb_ready);
  assign ex_ready   = w_ex_ready;
  assign w_accept   = ex_valid && w_ex_ready;
  assign w_is_mem   = ex_mem_read || ex_mem_write;
  assign w_size     = access_size(ex_funct3, ex_mem_read);

`ifdef MEM_MISALIGN_CHECK_EN
  assign w_misalign = w_is_mem && is_misaligned(w_size, ex_alu_result[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  // Store lanes are formatted at accept so the bus fields are plain registers in REQ.
  always_comb begin
    w_st_wdata = '0;
    w_st_be    = '0;
    if (!ex_mem_read) begin
      case (w_size)
        SZ_BYTE: begin
          w_st_wdata = {4{ex_reg_b[7:0]}};
          w_st_be    = 4'b0001 << ex_alu_result[1:0];
        end
        SZ_HALF: begin
          w_st_wdata = {2{ex_reg_b[15:0]}};
          w_st_be    = 4'b0011 << {ex_alu_result[1], 1'b0};
        end
        default: begin
          w_st_wdata = ex_reg_b;
          w_st_be    = 4'b1111;
        end
      endcase
    end
  end

  mem_load_align u_load_align (
    .i_funct3  (r_funct3),
    .i_addr_lo (r_addr[1:0]),
    .i_rdata   (dmem.dmem_rdata),
    .o_lmd     (w_lmd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_out_load  = 1'b0;
    w_nx_lmd    = '0;
    w_nx_m2r    = 1'b0;
    w_nx_alu    = r_addr;
    w_nx_rd     = r_rd;
    w_nx_rw     = r_reg_write;
    w_nx_cond   = r_cond;
    w_nx_npc    = r_npc;
    w_nx_condpc = r_condpc;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_is_mem && !w_misalign) begin
            w_latch     = 1'b1;
            w_state_nxt = REQ;
          end else begin
            w_out_load  = 1'b1;
            w_nx_alu    = ex_alu_result;
            w_nx_rd     = ex_rd;
            w_nx_rw     = ex_reg_write && !w_misalign;
            w_nx_cond   = ex_cond;
            w_nx_npc    = ex_npc;
            w_nx_condpc = ex_condpc;
          end
        end
      end
      REQ: begin
        if (dmem.dmem_gnt) begin
          if (r_is_load) begin
            w_state_nxt = RESP;
          end else begin
            w_out_load  = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      RESP: begin
        if (dmem.dmem_rvalid) begin
          w_out_load  = 1'b1;
          w_nx_lmd    = w_lmd;
          w_nx_m2r    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_funct3    <= '0;
      r_is_load   <= 1'b0;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_cond      <= 1'b0;
      r_npc       <= '0;
      r_condpc    <= '0;
    end else if (w_latch) begin
      r_addr      <= ex_alu_result;
      r_wdata     <= w_st_wdata;
      r_be        <= w_st_be;
      r_funct3    <= ex_funct3;
      r_is_load   <= ex_mem_read;
      r_rd        <= ex_rd;
      r_reg_write <= ex_reg_write;
      r_cond      <= ex_cond;
      r_npc       <= ex_npc;
      r_condpc    <= ex_condpc;
    end
  end

  // Accept requires the old result to be gone or leaving, so a load here never overwrites.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid  <= 1'b0;
      r_wb_lmd    <= '0;
      r_wb_alu    <= '0;
      r_wb_rd     <= '0;
      r_wb_rw     <= 1'b0;
      r_wb_m2r    <= 1'b0;
      r_wb_cond   <= 1'b0;
      r_wb_npc    <= '0;
      r_wb_condpc <= '0;
    end else if (w_out_load) begin
      r_wb_valid  <= 1'b1;
      r_wb_lmd    <= w_nx_lmd;
      r_wb_alu    <= w_nx_alu;
      r_wb_rd     <= w_nx_rd;
      r_wb_rw     <= w_nx_rw;
      r_wb_m2r    <= w_nx_m2r;
      r_wb_cond   <= w_nx_cond;
      r_wb_npc    <= w_nx_npc;
      r_wb_condpc <= w_nx_condpc;
    end else if (wb_ready) begin
      r_wb_valid  <= 1'b0;
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  logic r_wb_misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_wb_misalign <= 1'b0;
    else if (w_out_load) r_wb_misalign <= (r_state == IDLE) && w_misalign;
  end

  assign wb_misalign = r_wb_misalign;
`else
  assign wb_misalign = 1'b0;
`endif

  assign w_in_req        = (r_state == REQ);
  assign dmem.dmem_req   = w_in_req;
  assign dmem.dmem_we    = w_in_req && !r_is_load;
  assign dmem.dmem_addr  = w_in_req ? {r_addr[DATA_WIDTH-1:2], 2'b00} : '0;
  assign dmem.dmem_wdata = w_in_req ? r_wdata : '0;
  assign dmem.dmem_be    = w_in_req ? r_be : '0;

  assign wb_valid      = r_wb_valid;
  assign wb_lmd        = r_wb_lmd;
  assign wb_alu_result = r_wb_alu;
  assign wb_rd         = r_wb_rd;
  assign wb_reg_write  = r_wb_rw;
  assign wb_mem_to_reg = r_wb_m2r;
  assign wb_cond       = r_wb_cond;
  assign wb_npc        = r_wb_npc;
  assign wb_condpc     = r_wb_condpc;

endmodule
